// File: rtl/stage_buffer.sv
// stage_buffer: two-entry skid buffer between pipeline stages with flush and flush counter.
// Every downstream-facing output is a register, so nothing passes combinationally from in_* to out_*.
module stage_buffer #(
    parameter int PC_W = 8,
    parameter int DATA_W = 8,
    parameter int OP_W = 8,
    parameter logic [OP_W-1:0] NOP_OPCODE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_alu,
    output logic [OP_W-1:0]   out_opcode,
    output logic [1:0]        occupancy,
    output logic [7:0]        flush_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t state;
    logic [PC_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_alu;
    logic [OP_W-1:0] skid_op;
    logic acc, con;
    assign acc = in_valid && in_ready;
    assign con = out_valid && out_ready;
    assign occupancy = state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_pc <= '0;
            out_alu <= '0;
            out_opcode <= NOP_OPCODE;
            skid_pc <= '0;
            skid_alu <= '0;
            skid_op <= NOP_OPCODE;
            flush_count <= '0;
        end else if (flush) begin
            // Flush overrides accept and consume; only non-empty flushes are counted.
            if (state != EMPTY && flush_count != 8'hff) flush_count <= flush_count + 8'd1;
            state <= EMPTY;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
            out_pc <= '0;
            out_alu <= '0;
            out_opcode <= NOP_OPCODE;
            skid_pc <= '0;
            skid_alu <= '0;
            skid_op <= NOP_OPCODE;
        end else begin
            case (state)
                EMPTY: if (acc) begin
                    state <= ONE;
                    out_valid <= 1'b1;
                    out_pc <= in_pc;
                    out_alu <= in_alu;
                    out_opcode <= in_opcode;
                end
                ONE: if (acc && con) begin
                    out_pc <= in_pc;
                    out_alu <= in_alu;
                    out_opcode <= in_opcode;
                end else if (acc) begin
                    state <= TWO;
                    in_ready <= 1'b0;
                    skid_pc <= in_pc;
                    skid_alu <= in_alu;
                    skid_op <= in_opcode;
                end else if (con) begin
                    state <= EMPTY;
                    out_valid <= 1'b0;
                    out_pc <= '0;
                    out_alu <= '0;
                    out_opcode <= NOP_OPCODE;
                end
                TWO: if (con) begin
                    state <= ONE;
                    in_ready <= 1'b1;
                    out_pc <= skid_pc;
                    out_alu <= skid_alu;
                    out_opcode <= skid_op;
                    skid_pc <= '0;
                    skid_alu <= '0;
                    skid_op <= NOP_OPCODE;
                end
                default: begin
                    state <= EMPTY;
                    in_ready <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stage_buffer.sv
// tb_stage_buffer: directed vector table plus hand sequences for streaming, saturation and async reset.
module tb_stage_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [7:0] in_pc = '0, in_alu = '0, in_opcode = '0;
    logic [7:0] out_pc, out_alu, out_opcode, flush_count;
    logic [1:0] occupancy;
    int vecs = 0, errs = 0;

    stage_buffer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu(in_alu), .in_opcode(in_opcode), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_alu(out_alu), .out_opcode(out_opcode), .occupancy(occupancy),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [7:0] pc, alu, op; logic fl, ordy;
        logic e_v; logic [7:0] e_pc, e_alu, e_op; logic [1:0] e_occ; logic e_ir; logic [7:0] e_fc;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] pc, input logic [7:0] alu, input logic [7:0] op,
                         input logic fl, input logic ordy);
        in_valid = v; in_pc = pc; in_alu = alu; in_opcode = op; flush = fl; out_ready = ordy;
    endtask

    initial begin
        //         v  pc     alu    op     fl ordy e_v e_pc   e_alu  e_op   occ ir fc
        tbl[0]  = '{1, 8'h10, 8'h5A, 8'h23, 0, 1, 1, 8'h10, 8'h5A, 8'h23, 1, 1, 0};
        tbl[1]  = '{0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0};
        tbl[2]  = '{1, 8'h01, 8'h11, 8'h01, 0, 0, 1, 8'h01, 8'h11, 8'h01, 1, 1, 0};
        tbl[3]  = '{1, 8'h02, 8'h22, 8'h02, 0, 0, 1, 8'h01, 8'h11, 8'h01, 2, 0, 0};
        tbl[4]  = '{1, 8'h03, 8'h33, 8'h03, 0, 0, 1, 8'h01, 8'h11, 8'h01, 2, 0, 0};
        tbl[5]  = '{1, 8'h03, 8'h33, 8'h03, 0, 1, 1, 8'h02, 8'h22, 8'h02, 1, 1, 0};
        tbl[6]  = '{1, 8'h03, 8'h33, 8'h03, 0, 1, 1, 8'h03, 8'h33, 8'h03, 1, 1, 0};
        tbl[7]  = '{0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0};
        tbl[8]  = '{1, 8'h04, 8'h44, 8'h04, 0, 0, 1, 8'h04, 8'h44, 8'h04, 1, 1, 0};
        tbl[9]  = '{1, 8'h05, 8'h55, 8'h05, 0, 0, 1, 8'h04, 8'h44, 8'h04, 2, 0, 0};
        tbl[10] = '{1, 8'h06, 8'h66, 8'h06, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1};
        tbl[11] = '{0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1};
        tbl[12] = '{1, 8'h07, 8'h77, 8'h07, 0, 0, 1, 8'h07, 8'h77, 8'h07, 1, 1, 1};
        tbl[13] = '{0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h07, 8'h77, 8'h07, 1, 1, 1};
        tbl[14] = '{0, 8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1};

        #12;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_occ", 32'(occupancy), 0);
        chk("reset_op", 32'(out_opcode), 0);
        chk("reset_fc", 32'(flush_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].alu, tbl[i].op, tbl[i].fl, tbl[i].ordy);
            step();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_v));
            chk($sformatf("v%0d_pc", i), 32'(out_pc), 32'(tbl[i].e_pc));
            chk($sformatf("v%0d_alu", i), 32'(out_alu), 32'(tbl[i].e_alu));
            chk($sformatf("v%0d_op", i), 32'(out_opcode), 32'(tbl[i].e_op));
            chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("v%0d_fc", i), 32'(flush_count), 32'(tbl[i].e_fc));
        end

        // streaming: head always holds the entry accepted on the previous edge
        for (int i = 0; i < 20; i++) begin
            drive(1, 8'(i + 8'h40), 8'(i), 8'h0A, 0, 1);
            step();
            chk($sformatf("stream%0d_pc", i), 32'(out_pc), 32'(i + 8'h40));
            chk($sformatf("stream%0d_occ", i), 32'(occupancy), 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("stream_drain", 32'(out_valid), 0);

        // saturation: fill one, flush it, 300 times (count starts at 1)
        for (int i = 0; i < 300; i++) begin
            drive(1, 8'h99, 8'h99, 8'h09, 0, 0);
            step();
            drive(0, 0, 0, 0, 1, 0);
            step();
        end
        chk("sat_fc", 32'(flush_count), 255);
        chk("sat_occ", 32'(occupancy), 0);

        // async reset with two entries held
        drive(1, 8'hA1, 8'h01, 8'h11, 0, 0);
        step();
        drive(1, 8'hA2, 8'h02, 8'h12, 0, 0);
        step();
        chk("pre_rst_occ", 32'(occupancy), 2);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 0);
        chk("async_fc", 32'(flush_count), 0);
        chk("async_occ", 32'(occupancy), 0);
        chk("async_pc", 32'(out_pc), 0);
        #2;
        rst_n = 1'b1;
        drive(1, 8'hB0, 8'hB1, 8'hB2, 0, 1);
        step();
        chk("post_rst_pc", 32'(out_pc), 32'hB0);
        chk("post_rst_valid", 32'(out_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/stage_buffer.md
STAGE_BUFFER -- requirements
Module: stage_buffer

Interface
REQ-001 The block SHALL expose parameter PC_W, default 8, PC field width.
REQ-002 The block SHALL expose parameter DATA_W, default 8, ALU result field width.
REQ-003 The block SHALL expose parameter OP_W, default 8, opcode field width.
REQ-004 The block SHALL expose parameter NOP_OPCODE, default all-zero OP_W value, opcode presented when no valid entry.
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port in_valid  input  1  upstream entry present.
REQ-008 The block SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-009 The block SHALL have ports in_pc  input  PC_W, in_alu  input  DATA_W, in_opcode  input  OP_W  upstream payload.
REQ-010 The block SHALL have port flush  input  1  discard all held entries (branch taken / hazard kill).
REQ-011 The block SHALL have port out_valid  output  1  head entry present for downstream stage.
REQ-012 The block SHALL have port out_ready  input  1  downstream consumes head this cycle.
REQ-013 The block SHALL have ports out_pc  output  PC_W, out_alu  output  DATA_W, out_opcode  output  OP_W  head payload.
REQ-014 The block SHALL have port occupancy  output  2  number of held entries (0..2).
REQ-015 The block SHALL have port flush_count  output  8  saturating count of flushes that discarded at least one entry.

Function
REQ-016 Storage SHALL be a 2-entry skid buffer: head register (drives outputs) and skid register; states EMPTY, ONE, TWO matching occupancy.
REQ-017 Accept SHALL occur when in_valid && in_ready at a rising edge; consume SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be a registered-state function: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL be 1 exactly in ONE and TWO; all out_* SHALL be direct register outputs (no combinational path from in_* to out_*).
REQ-020 Latency SHALL be one cycle: an entry accepted in EMPTY appears on out_* the next cycle.
REQ-021 Transitions: EMPTY+accept->ONE; ONE+accept only->TWO (entry to skid); ONE+consume only->EMPTY; ONE+accept+consume->ONE (new entry to head); TWO+consume->ONE (skid moves to head); otherwise hold.
REQ-022 Order SHALL be strictly FIFO; no entry duplicated or lost except by flush.
REQ-023 When out_valid=0, out_opcode SHALL equal NOP_OPCODE and out_pc, out_alu SHALL be 0.
REQ-024 flush SHALL take priority over accept and consume in the same cycle: next state EMPTY, in_valid that cycle ignored, consume that cycle not counted as delivered.
REQ-025 flush_count SHALL increment by 1 when flush=1 and occupancy>0, saturating at 255; flush in EMPTY SHALL NOT increment.
REQ-026 Payload held in head SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 On rst_n=0, asynchronously: state EMPTY, occupancy 0, out_valid 0, in_ready 1 (once released), out_opcode NOP_OPCODE, out_pc 0, out_alu 0, flush_count 0, skid cleared to 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately without waiting for a clock edge; first accept possible on first rising edge with rst_n=1.

Verification
REQ-029 Single pass: reset, in_valid=1 pc=0x10 alu=0x5A op=0x23, out_ready=1 -> next cycle out_valid=1, out_pc=0x10, out_alu=0x5A, out_opcode=0x23; following cycle with in_valid=0 -> out_valid=0, out_opcode=0x00.
REQ-030 Backpressure: out_ready=0, push A(pc 0x01) then B(pc 0x02) -> occupancy 2, in_ready=0, C held off; raise out_ready -> outputs A, B, C in order, no loss.
REQ-031 Streaming: in_valid=1 and out_ready=1 every cycle for 20 cycles, pc incrementing -> occupancy stays 1, out_pc lags in_pc by one cycle, throughput 1/cycle.
REQ-032 Flush priority: occupancy 2, assert flush with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid 0, flush_count 1; flush again when empty -> flush_count stays 1.
REQ-033 Saturation and async reset: 300 flushes each with occupancy 1 -> flush_count 255; drop rst_n between clock edges with occupancy 2 -> out_valid 0, flush_count 0 before next edge.
